lcd_init_seq: RTL
=================

// Module: lcd_init_seq
// PURPOSE
//   Power-up sequencer for the ST7735R SPI panel; sits directly upstream of lcd_write.
//   Drives the panel hardware reset, then streams a fixed init command table as 9-bit
//   {dc,byte} words to lcd_write, one en_write/wr_done handshake per word.
//   Inserts ms delays after SWRESET/SLPOUT, then asserts init_done for the drawing logic.
// PARAMETERS
//   CNT_1MS      50_000  sys_clk cycles per 1 ms tick (50 MHz)
//   RST_LOW_MS   10      lcd_rst low time after reset release, ms
//   RST_WAIT_MS  120     wait after lcd_rst rises before first command, ms
//   CMD_WAIT_MS  120     wait after SWRESET and after SLPOUT, ms
//   LCD_W        128     panel width, pixels (clear feature)
//   LCD_H        160     panel height, pixels (clear feature)
//   CLEAR_COLOR  16'h0000 RGB565 fill colour (clear feature)
// PORTS
//   sys_clk    in   1  system clock
//   sys_rst_n  in   1  async reset, active low
//   wr_done    in   1  1-cycle pulse from lcd_write: current word shifted out
//   en_write   out  1  1-cycle pulse: start write of data
//   data       out  9  {dc, byte}; dc=0 command, dc=1 parameter/pixel
//   lcd_rst    out  1  panel hardware reset, active low
//   init_done  out  1  high (sticky) once sequence complete
// BEHAVIOUR
//   Reset values: en_write=0, data=9'h000, lcd_rst=0, init_done=0; FSM->RST_LOW, counters 0.
//   ms timer: cnt_clk counts 0..CNT_1MS-1 only in RST_LOW/RST_WAIT/DELAY; wrap gives tick,
//     cnt_ms counts ticks; both clear on every state entry.
//   FSM: RST_LOW (lcd_rst=0) --RST_LOW_MS ticks--> RST_WAIT (lcd_rst=1) --RST_WAIT_MS-->
//     SEND --> WAIT_DONE --wr_done--> DELAY if entry flagged else NEXT; DELAY --CMD_WAIT_MS-->
//     NEXT; NEXT: idx+1, back to SEND, or DONE after last entry. DONE: absorbing, init_done=1.
//   SEND lasts exactly 1 cycle, en_write=1 in it; data loaded from table on entry to SEND.
//   data held stable from SEND until next SEND (lcd_write samples data and dc throughout).
//   Next en_write no earlier than 2 cycles after wr_done (via NEXT); never 2 en_write
//     without an intervening wr_done. wr_done outside WAIT_DONE is ignored.
//   Table (idx: data, delay flag): 0:0_01 SWRESET D; 1:0_11 SLPOUT D; 2:0_3A COLMOD;
//     3:1_05 (16bpp); 4:0_36 MADCTL; 5:1_C8; 6:0_29 DISPON. 7 words, 2 delays.
//   lcd_rst stays 1 from RST_WAIT onward; any sys_rst_n low mid-sequence aborts instantly,
//     restarts from RST_LOW, lcd_rst=0, init_done=0.
//   No timeout: missing wr_done stalls in WAIT_DONE indefinitely (by design).
// CONFIGURATION
//   LCD_INIT_CLEAR_EN defined: after DISPON, append 0_2A,1_00,1_00,1_00,1_(LCD_W-1),
//     0_2B,1_00,1_00,1_00,1_(LCD_H-1), 0_2C, then LCD_W*LCD_H pixels, each as
//     1_{CLEAR_COLOR[15:8]} then 1_{CLEAR_COLOR[7:0]}; pixel counter 15 bits, wraps to 0
//     at last pixel then DONE. init_done only after final pixel's wr_done.
//   Undefined: table ends at DISPON; no pixel counter logic synthesized.
// TESTING (CNT_1MS=4, RST_LOW_MS=2, RST_WAIT_MS=3, CMD_WAIT_MS=2, wr_done model 20 cyc)
//   Release reset -> lcd_rst low 8 cycles, then high; first en_write 12 cycles later, data=9'h001.
//   Full run, clear off -> exactly 7 en_write pulses, data seq 001,011,03A,105,036,1C8,029; init_done=1.
//   After SWRESET wr_done -> next en_write delayed >=8 cycles; after COLMOD wr_done -> within 2-3.
//   Hold wr_done low 1000 cycles in WAIT_DONE -> no extra en_write, data unchanged; spurious
//     wr_done in DELAY -> no effect.
//   Assert sys_rst_n low during idx 3 -> outputs to reset values at once; re-release restarts at 001.
//   LCD_INIT_CLEAR_EN, LCD_W=2, LCD_H=2, CLEAR_COLOR=16'hF800 -> 7+11+8 pulses, last 8 alternate 1F8/100.

Source files
------------

// File: rtl/lcd_init_seq.sv
// lcd_init_seq: power-up sequencer for the ST7735R SPI panel.
// Pulses the panel hardware reset, then streams the init command table to
// lcd_write as 9-bit {dc,byte} words, one en_write/wr_done handshake per word.
// It inserts ms delays after SWRESET and SLPOUT, then holds init_done high.
// Optional feature: define LCD_INIT_CLEAR_EN to append a full-screen clear
// (window setup, RAMWR, LCD_W*LCD_H pixels of CLEAR_COLOR) after DISPON.
module lcd_init_seq #(
  parameter int unsigned CNT_1MS     = 50_000,
  parameter int unsigned RST_LOW_MS  = 10,
  parameter int unsigned RST_WAIT_MS = 120,
  parameter int unsigned CMD_WAIT_MS = 120,
  parameter int unsigned LCD_W       = 128,
  parameter int unsigned LCD_H       = 160,
  parameter logic [15:0] CLEAR_COLOR = 16'h0000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       wr_done,
  output logic       en_write,
  output logic [8:0] data,
  output logic       lcd_rst,
  output logic       init_done
);

  localparam int unsigned CLK_W  = (CNT_1MS > 1) ? $clog2(CNT_1MS) : 1;
  localparam int unsigned MS_MAX = (RST_LOW_MS > RST_WAIT_MS)
                                   ? ((RST_LOW_MS > CMD_WAIT_MS) ? RST_LOW_MS : CMD_WAIT_MS)
                                   : ((RST_WAIT_MS > CMD_WAIT_MS) ? RST_WAIT_MS : CMD_WAIT_MS);
  localparam int unsigned MS_W   = (MS_MAX > 1) ? $clog2(MS_MAX) : 1;

  localparam logic [4:0] IDX_DISPON = 5'd6;
`ifdef LCD_INIT_CLEAR_EN
  localparam logic [4:0]  IDX_PIX_HI = 5'd18;
  localparam logic [4:0]  IDX_PIX_LO = 5'd19;
  localparam logic [14:0] PIX_LAST   = 15'(LCD_W * LCD_H - 1);
`endif

  typedef enum logic [2:0] {
    S_RST_LOW,
    S_RST_WAIT,
    S_SEND,
    S_WAIT_DONE,
    S_DELAY,
    S_NEXT,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CLK_W-1:0] cnt_clk_q, cnt_clk_d;
  logic [MS_W-1:0]  cnt_ms_q, cnt_ms_d;
  logic [MS_W-1:0]  ms_target;
  logic             timed, tick, ms_done;
  logic [4:0]       idx_q, idx_d;
  logic [8:0]       data_q, data_d;
`ifdef LCD_INIT_CLEAR_EN
  logic [14:0]      pix_cnt_q, pix_cnt_d;
`endif

  // Word table. Entries 7..17 are the clear window setup; 18/19 are the
  // two bytes of one pixel, replayed by toggling idx between them.
  function automatic logic [8:0] tbl_word(input logic [4:0] i);
    case (i)
      5'd0:    tbl_word = 9'h001;                       // SWRESET
      5'd1:    tbl_word = 9'h011;                       // SLPOUT
      5'd2:    tbl_word = 9'h03A;                       // COLMOD
      5'd3:    tbl_word = 9'h105;                       // 16 bpp
      5'd4:    tbl_word = 9'h036;                       // MADCTL
      5'd5:    tbl_word = 9'h1C8;
      5'd6:    tbl_word = 9'h029;                       // DISPON
      5'd7:    tbl_word = 9'h02A;                       // CASET
      5'd8:    tbl_word = 9'h100;
      5'd9:    tbl_word = 9'h100;
      5'd10:   tbl_word = 9'h100;
      5'd11:   tbl_word = {1'b1, 8'(LCD_W - 1)};
      5'd12:   tbl_word = 9'h02B;                       // RASET
      5'd13:   tbl_word = 9'h100;
      5'd14:   tbl_word = 9'h100;
      5'd15:   tbl_word = 9'h100;
      5'd16:   tbl_word = {1'b1, 8'(LCD_H - 1)};
      5'd17:   tbl_word = 9'h02C;                       // RAMWR
      5'd18:   tbl_word = {1'b1, CLEAR_COLOR[15:8]};
      5'd19:   tbl_word = {1'b1, CLEAR_COLOR[7:0]};
      default: tbl_word = 9'h000;
    endcase
  endfunction

  // Only SWRESET and SLPOUT need the settle delay afterwards.
  function automatic logic tbl_delay(input logic [4:0] i);
    tbl_delay = (i == 5'd0) || (i == 5'd1);
  endfunction

  // ms timer decode: counters run only in the three timed states.
  always_comb begin
    timed     = (state_q == S_RST_LOW) || (state_q == S_RST_WAIT) || (state_q == S_DELAY);
    ms_target = MS_W'(CMD_WAIT_MS - 1);
    if (state_q == S_RST_LOW)  ms_target = MS_W'(RST_LOW_MS - 1);
    if (state_q == S_RST_WAIT) ms_target = MS_W'(RST_WAIT_MS - 1);
    tick    = timed && (cnt_clk_q == CLK_W'(CNT_1MS - 1));
    ms_done = tick && (cnt_ms_q == ms_target);
  end

  // Next-state, table index, pixel counter, counters and data word.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_clk_d = cnt_clk_q;
    cnt_ms_d  = cnt_ms_q;
    data_d    = data_q;
`ifdef LCD_INIT_CLEAR_EN
    pix_cnt_d = pix_cnt_q;
`endif

    case (state_q)
      S_RST_LOW:   if (ms_done) state_d = S_RST_WAIT;
      S_RST_WAIT:  if (ms_done) state_d = S_SEND;
      S_SEND:      state_d = S_WAIT_DONE;
      S_WAIT_DONE: if (wr_done) state_d = tbl_delay(idx_q) ? S_DELAY : S_NEXT;
      S_DELAY:     if (ms_done) state_d = S_NEXT;
      S_NEXT: begin
        state_d = S_SEND;
        idx_d   = idx_q + 5'd1;
`ifdef LCD_INIT_CLEAR_EN
        // After the low byte, go back to the high byte or finish the frame.
        if (idx_q == IDX_PIX_LO) begin
          idx_d = IDX_PIX_HI;
          if (pix_cnt_q == PIX_LAST) begin
            pix_cnt_d = '0;
            state_d   = S_DONE;
          end else begin
            pix_cnt_d = pix_cnt_q + 15'd1;
          end
        end
`else
        if (idx_q == IDX_DISPON) state_d = S_DONE;
`endif
      end
      S_DONE:      state_d = S_DONE;
      default:     state_d = S_RST_LOW;
    endcase

    if (state_d != state_q) begin
      cnt_clk_d = '0;
      cnt_ms_d  = '0;
    end else if (timed) begin
      if (tick) begin
        cnt_clk_d = '0;
        cnt_ms_d  = cnt_ms_q + 1'b1;
      end else begin
        cnt_clk_d = cnt_clk_q + 1'b1;
      end
    end

    if (state_d == S_SEND) data_d = tbl_word(idx_d);
  end

  // State and datapath registers; reset aborts any sequence in progress.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= S_RST_LOW;
      idx_q     <= '0;
      cnt_clk_q <= '0;
      cnt_ms_q  <= '0;
      data_q    <= '0;
`ifdef LCD_INIT_CLEAR_EN
      pix_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_clk_q <= cnt_clk_d;
      cnt_ms_q  <= cnt_ms_d;
      data_q    <= data_d;
`ifdef LCD_INIT_CLEAR_EN
      pix_cnt_q <= pix_cnt_d;
`endif
    end
  end

  assign en_write  = (state_q == S_SEND);
  assign lcd_rst   = (state_q != S_RST_LOW);
  assign init_done = (state_q == S_DONE);
  assign data      = data_q;

endmodule
